// File: rtl/rr_index_arbiter.sv
// 64-way arbiter: reduces a request vector to one registered 6-bit index behind a valid/ready handshake.
// Define RR_ARB_ROUND_ROBIN_EN for a rotating priority pointer; otherwise the lowest set request always wins.
module rr_index_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] req,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [5:0]  out_idx
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t     state;
    state_t     state_next;
    logic       valid_next;
    logic [5:0] idx_next;
    logic [5:0] base;
    logic [5:0] pick;
    logic       any_req;

    // Wrap-around search: first set bit at or above p, else the first set bit below p.
    function automatic logic [5:0] sel(input logic [5:0] p, input logic [63:0] r);
        logic [5:0] result;
        logic [5:0] k;
        logic       found;
        result = 6'd0;
        found  = 1'b0;
        for (int i = 0; i < 64; i++) begin
            k = p + 6'(i);
            if (!found && r[k]) begin
                result = k;
                found  = 1'b1;
            end
        end
        return result;
    endfunction

`ifdef RR_ARB_ROUND_ROBIN_EN
    logic [5:0] ptr;
    logic [5:0] ptr_next;

    // A back-to-back grant searches from just past the grant being accepted.
    assign base = (state == IDLE) ? ptr : out_idx + 6'd1;
`else
    assign base = 6'd0;
`endif

    assign any_req = |req;
    assign pick    = sel(base, req);

    always_comb begin
        state_next = state;
        valid_next = out_valid;
        idx_next   = out_idx;
`ifdef RR_ARB_ROUND_ROBIN_EN
        ptr_next   = ptr;
`endif
        case (state)
            IDLE: begin
                if (any_req) begin
                    idx_next   = pick;
                    valid_next = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
`ifdef RR_ARB_ROUND_ROBIN_EN
                    ptr_next = out_idx + 6'd1;
`endif
                    if (any_req) begin
                        idx_next = pick;
                    end else begin
                        valid_next = 1'b0;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_idx   <= 6'd0;
`ifdef RR_ARB_ROUND_ROBIN_EN
            ptr       <= 6'd0;
`endif
        end else begin
            state     <= state_next;
            out_valid <= valid_next;
            out_idx   <= idx_next;
`ifdef RR_ARB_ROUND_ROBIN_EN
            ptr       <= ptr_next;
`endif
        end
    end

endmodule

// File: tb/tb_rr_index_arbiter.sv
// Self-checking bench for rr_index_arbiter: vector table plus hand sequences, checked through a scoreboard queue.
module tb_rr_index_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] req;
    logic        out_ready;
    logic        out_valid;
    logic [5:0]  out_idx;

    always #5 clk = ~clk;

    rr_index_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_idx   (out_idx)
    );

`ifdef RR_ARB_ROUND_ROBIN_EN
    localparam bit ROUND_ROBIN = 1'b1;
`else
    localparam bit ROUND_ROBIN = 1'b0;
`endif

    typedef struct {
        string       name;
        logic        rst;
        logic [63:0] req;
        logic        out_ready;
        logic        exp_valid;
        logic [5:0]  exp_rr;
        logic [5:0]  exp_fp;
    } vec_t;

    typedef struct {
        string      name;
        logic       valid;
        logic [5:0] idx;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    function automatic vec_t mk(string n, logic r, logic [63:0] q, logic rdy,
                                logic v, logic [5:0] irr, logic [5:0] ifp);
        vec_t t;
        t.name = n; t.rst = r; t.req = q; t.out_ready = rdy;
        t.exp_valid = v; t.exp_rr = irr; t.exp_fp = ifp;
        return t;
    endfunction

    function automatic logic [63:0] bits3(int a, int b, int c);
        return (64'd1 << a) | (64'd1 << b) | (64'd1 << c);
    endfunction

    task automatic check_output();
        exp_t e;
        if (sb.size() == 0) begin
            mismatched++;
            compared++;
            $display("[TB] FAIL scoreboard_empty: got valid=%0d idx=%0d, required a queued expectation", out_valid, out_idx);
            return;
        end
        e = sb.pop_front();
        compared++;
        if (out_valid !== e.valid) begin
            mismatched++;
            $display("[TB] FAIL %s valid: got %0d, required %0d", e.name, out_valid, e.valid);
        end
        compared++;
        if (out_idx !== e.idx) begin
            mismatched++;
            $display("[TB] FAIL %s idx: got %0d, required %0d", e.name, out_idx, e.idx);
        end
    endtask

    // Drive one cycle of inputs, queue the expectation, and check just after the edge.
    task automatic apply_stimulus(string n, logic r, logic [63:0] q, logic rdy,
                                  logic v, logic [5:0] irr, logic [5:0] ifp);
        exp_t e;
        @(negedge clk);
        rst = r; req = q; out_ready = rdy;
        e.name = n; e.valid = v; e.idx = ROUND_ROBIN ? irr : ifp;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_output();
    endtask

    initial begin
        logic [63:0] all_ones;
        logic [63:0] r3;
        logic [63:0] r2;
        exp_t        e;
        int          lat;
        all_ones = '1;
        r3 = bits3(3, 10, 63);
        r2 = (64'd1 << 0) | (64'd1 << 63);
        rst = 1'b1; req = '0; out_ready = 1'b0;

        vecs.push_back(mk("reset0",     1, all_ones, 1, 0, 0, 0));
        vecs.push_back(mk("reset1",     1, all_ones, 1, 0, 0, 0));
        vecs.push_back(mk("first",      0, all_ones, 1, 1, 0, 0));
        vecs.push_back(mk("single_a",   0, 64'd1 << 5, 1, 1, 5, 5));
        vecs.push_back(mk("single_b",   0, 64'd1 << 5, 1, 1, 5, 5));
        vecs.push_back(mk("single_c",   0, 64'd1 << 5, 1, 1, 5, 5));
        vecs.push_back(mk("drop_req",   0, 64'd0, 1, 0, 5, 5));
        vecs.push_back(mk("idle_keep",  0, 64'd0, 1, 0, 5, 5));
        vecs.push_back(mk("rot_0",      0, r3, 1, 1, 10, 3));
        vecs.push_back(mk("rot_1",      0, r3, 1, 1, 63, 3));
        vecs.push_back(mk("rot_wrap",   0, r3, 1, 1, 3, 3));
        vecs.push_back(mk("rot_3",      0, r3, 1, 1, 10, 3));
        vecs.push_back(mk("rot_4",      0, r3, 1, 1, 63, 3));
        vecs.push_back(mk("rot_5",      0, r3, 1, 1, 3, 3));
        vecs.push_back(mk("rot_6",      0, r3, 1, 1, 10, 3));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk("bp_hold",  0, 64'd1 << 20, 0, 1, 10, 3));
        vecs.push_back(mk("bp_release", 0, 64'd1 << 20, 1, 1, 20, 20));
        vecs.push_back(mk("bp_hold20",  0, 64'd1 << 20, 0, 1, 20, 20));
        vecs.push_back(mk("to_63",      0, r2, 1, 1, 63, 0));
        vecs.push_back(mk("rst_on_hs",  1, r2, 1, 0, 0, 0));
        vecs.push_back(mk("after_rst",  0, r2, 0, 1, 0, 0));
        vecs.push_back(mk("hold_noreq", 0, 64'd0, 0, 1, 0, 0));
        vecs.push_back(mk("hs_empty",   0, 64'd0, 1, 0, 0, 0));

        foreach (vecs[i])
            apply_stimulus(vecs[i].name, vecs[i].rst, vecs[i].req, vecs[i].out_ready,
                           vecs[i].exp_valid, vecs[i].exp_rr, vecs[i].exp_fp);

        // Latency from IDLE, with a bounded wait for the grant.
        @(negedge clk);
        req = 64'd1 << 42; out_ready = 1'b0;
        e.name = "latency_idx"; e.valid = 1'b1; e.idx = 6'd42;
        sb.push_back(e);
        lat = 0;
        while (lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid === 1'b1) break;
        end
        if (out_valid !== 1'b1) begin
            void'(sb.pop_front());
            compared++;
            mismatched++;
            $display("[TB] FAIL latency_timeout: got no valid after %0d cycles, required 1", lat);
        end else begin
            check_output();
            compared++;
            if (lat != 1) begin
                mismatched++;
                $display("[TB] FAIL latency_cycles: got %0d, required 1", lat);
            end
        end

        // Granted bit drops during backpressure; grant must stay put.
        for (int i = 0; i < 3; i++)
            apply_stimulus("bp_drop", 0, 64'd0, 0, 1, 42, 42);
        apply_stimulus("bp_drop_hs", 0, 64'd0, 1, 0, 42, 42);
        // Empty handshake still advanced the pointer past 42.
        apply_stimulus("ptr_adv", 0, (64'd1 << 42) | (64'd1 << 50), 0, 1, 50, 42);

        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL scoreboard_drain: got %0d left, required 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
